// File: rtl/date_pkg.sv
// date_pkg: shared state encoding, size defaults and ASCII constants for the date-scan
// scheduler, its recognizer and testbenches.
package date_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_SAMPLE, S_REPORT} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_LEN_DEF = 16;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CH_SLASH = 8'h2f;
  localparam logic [7:0] CH_DOT = 8'h2e;
  localparam logic [7:0] CH_DASH = 8'h2d;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the requester after the last grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_valid,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_c;
  // walk the ring farthest-first so the nearest valid requester wins the last overwrite
  always_comb begin
    w_c = '0;
    o_idx = '0;
    for (int k = N; k >= 1; k--) begin
      w_c = IW'((int'(i_last) + k) % N);
      o_idx = i_valid[w_c] ? w_c : o_idx;
    end
    o_any = |i_valid;
    o_gnt = o_any ? (N'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/date_scan_sched.sv
// date_scan_sched: shares one free-running date recognizer among N_REQ byte streams by buffering
// a granted string, replaying it back-to-back into the cleared recognizer and reporting the match.
module date_scan_sched
  import date_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [8*N_REQ-1:0]           req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rec_clr,
  output logic [7:0]                   rec_in,
  input  logic                         rec_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(N_REQ)-1:0]     res_id,
  output logic                         res_hit,
  output logic                         res_ovf,
  output logic [$clog2(MAX_LEN+1)-1:0] res_len
);
  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = $clog2(MAX_LEN);
  state_t r_state, w_next;
  logic [IW-1:0] r_g, r_last, w_pick;
  logic [N_REQ-1:0] r_gnt, w_onehot;
  logic [LW-1:0] r_len, r_idx;
  logic [7:0] r_buf [MAX_LEN];
  logic r_ovf, r_hit, r_rec_clr;
  logic w_any, w_acc, w_last, w_full;
  logic [7:0] w_char;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_valid(req_valid),
    .i_last (r_last),
    .o_gnt  (w_onehot),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  assign w_acc = r_state == S_LOAD && req_valid[r_g];
  assign w_last = req_last[r_g];
  assign w_char = req_data[{r_g, 3'b000} +: 8];
  assign w_full = r_len == LW'(MAX_LEN);

  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_any ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = (w_acc && w_last) ? ((r_ovf || w_full) ? S_REPORT : S_PLAY) : S_LOAD;
      S_PLAY:   w_next = (r_idx == r_len - LW'(1)) ? S_SAMPLE : S_PLAY;
      S_SAMPLE: w_next = S_REPORT;
      S_REPORT: w_next = res_ready ? S_IDLE : S_REPORT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = r_state == S_LOAD ? r_gnt : '0;
    rec_in = r_state == S_PLAY ? r_buf[r_idx[BW-1:0]] : 8'h00;
    res_valid = r_state == S_REPORT;
  end

  // registered from the next state so the recognizer runs exactly during PLAY and SAMPLE
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_rec_clr <= 1'b1;
    else r_rec_clr <= !(w_next == S_PLAY || w_next == S_SAMPLE);

  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_g <= '0;
      r_gnt <= '0;
      r_last <= IW'(N_REQ - 1);
      r_len <= '0;
      r_idx <= '0;
      r_ovf <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_g <= w_pick;
        r_gnt <= w_onehot;
      end
      if (w_acc && !w_full) r_len <= r_len + LW'(1);
      if (w_acc && w_full) r_ovf <= 1'b1;
      r_idx <= r_state == S_PLAY ? r_idx + LW'(1) : '0;
      if (r_state == S_LOAD) r_hit <= 1'b0;
      if (r_state == S_SAMPLE) r_hit <= rec_out;
      if (r_state == S_REPORT && res_ready) begin
        r_last <= r_g;
        r_len <= '0;
        r_ovf <= 1'b0;
      end
    end

  always_ff @(posedge clk)
    if (w_acc && !w_full) r_buf[r_len[BW-1:0]] <= w_char;

  assign rec_clr = r_rec_clr;
  assign res_id = r_g;
  assign res_hit = r_hit;
  assign res_ovf = r_ovf;
  assign res_len = r_len;
endmodule
